// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MIPS load/store sequencer with big-endian byte lanes and read-modify-write sub-word stores
module mem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req,
    input  logic [5:0]       op,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      rdata,
    output logic             fault,
    output logic [31:0]      mem_addr,
    output logic [0:3][7:0]  mem_data_in,
    output logic             mem_write_en,
    input  logic [0:3][7:0]  mem_data_out
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t          state;
    logic [5:0]      op_r;
    logic [1:0]      a_r;
    logic [31:0]     wbuf;
    logic [3:0]      cnt;
    logic            legal;
    logic            misal;
    logic            load_r;
    logic [7:0]      sel_b;
    logic [15:0]     sel_h;
    logic [31:0]     ld_val;
    logic [0:3][7:0] merged;

    // Classify the incoming request so IDLE can route straight to a fault completion.
    always_comb begin
        legal = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        misal = (op inside {OP_LH, OP_LHU, OP_SH} && addr[0]) ||
                (op inside {OP_LW, OP_SW} && addr[1:0] != 2'b00);
    end

    // Extract and extend the load result from the word being sampled; byte 0 is the most significant lane.
    always_comb begin
        load_r = op_r inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        sel_b  = mem_data_out[a_r];
        sel_h  = {mem_data_out[{a_r[1], 1'b0}], mem_data_out[{a_r[1], 1'b1}]};
        ld_val = op_r == OP_LB  ? {{24{sel_b[7]}}, sel_b} :
                 op_r == OP_LBU ? {24'b0, sel_b} :
                 op_r == OP_LH  ? {{16{sel_h[15]}}, sel_h} :
                 op_r == OP_LHU ? {16'b0, sel_h} : mem_data_out;
    end

    // Splice the store bytes into the sampled word for the sub-word read-modify-write.
    always_comb begin
        merged = mem_data_out;
        if (op_r == OP_SB)
            merged[a_r] = wbuf[7:0];
        else if (op_r == OP_SH) begin
            merged[{a_r[1], 1'b0}] = wbuf[15:8];
            merged[{a_r[1], 1'b1}] = wbuf[7:0];
        end
    end

    // Access sequencer: IDLE accepts, RD waits out the memory latency, WR issues one write, DONE pulses.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state    <= IDLE;
            done     <= 1'b0;
            fault    <= 1'b0;
            rdata    <= '0;
            mem_addr <= '0;
            cnt      <= '0;
            op_r     <= '0;
            a_r      <= '0;
            wbuf     <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    mem_addr <= {addr[31:2], 2'b00};
                    op_r     <= op;
                    a_r      <= addr[1:0];
                    wbuf     <= wdata;
                    cnt      <= 4'(MEM_LAT - 1);
                    fault    <= !legal || misal;
                    done     <= !legal || misal;
                    state    <= (!legal || misal) ? DONE : op == OP_SW ? WR : RD;
                end
                RD: if (cnt == 4'd0) begin
                    if (load_r) begin
                        rdata <= ld_val;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wbuf  <= merged;
                        state <= WR;
                    end
                end else
                    cnt <= cnt - 4'd1;
                WR: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = state != IDLE;
    assign mem_write_en = state == WR && !rst_b;
    assign mem_data_in  = mem_write_en ? wbuf : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of mem_access_ctrl against a spec-level model
module tb_mem_access_ctrl;
    localparam int L = 1;
    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

    logic clk = 0, rst_b = 1, req = 0;
    logic [5:0] op = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic busy, done, fault, mem_write_en;
    logic [31:0] rdata, mem_addr;
    logic [0:3][7:0] mem_data_in, mem_data_out;

    logic [31:0] mem [16];
    logic [31:0] mem_ref [16];
    logic pl_en = 0;
    logic [3:0] pl_idx = 0;
    logic [31:0] pl_val = 0;
    int wr_cnt = 0;
    logic [31:0] last_wd = 0;
    logic [31:0] ref_rd = 0;
    int total = 0, pass = 0;

    mem_access_ctrl #(.MEM_LAT(L)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .fault(fault), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr[5:2]] <= mem_data_in;
            last_wd <= mem_data_in;
            wr_cnt <= wr_cnt + 1;
        end else if (pl_en)
            mem[pl_idx] <= pl_val;
    end

    function automatic logic ref_fault(logic [5:0] o, logic [31:0] a);
        case (o)
            LB, LBU, SB: return 1'b0;
            LH, LHU, SH: return a[0];
            LW, SW:      return a[1:0] != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic is_load(logic [5:0] o);
        return o == LB || o == LH || o == LW || o == LBU || o == LHU;
    endfunction

    function automatic logic is_store(logic [5:0] o);
        return o == SB || o == SH || o == SW;
    endfunction

    function automatic int ref_lat(logic [5:0] o, logic [31:0] a);
        if (ref_fault(o, a)) return 1;
        if (is_load(o)) return L + 1;
        if (o == SW) return 2;
        return L + 2;
    endfunction

    function automatic logic [31:0] ref_load(logic [5:0] o, logic [31:0] a, logic [31:0] w);
        int k = int'(a[1:0]);
        logic [31:0] b = (w >> (24 - 8 * k)) & 32'hFF;
        logic [31:0] h = (w >> (16 - 16 * int'(a[1]))) & 32'hFFFF;
        case (o)
            LB:      return b[7] ? (b | 32'hFFFFFF00) : b;
            LBU:     return b;
            LH:      return h[15] ? (h | 32'hFFFF0000) : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(logic [5:0] o, logic [31:0] a, logic [31:0] w, logic [31:0] d);
        int s;
        if (o == SW) return d;
        if (o == SB) begin
            s = 24 - 8 * int'(a[1:0]);
            return (w & ~(32'hFF << s)) | ((d & 32'hFF) << s);
        end
        s = 16 - 16 * int'(a[1]);
        return (w & ~(32'hFFFF << s)) | ((d & 32'hFFFF) << s);
    endfunction

    task automatic preload(input int i, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1; pl_idx = 4'(i); pl_val = v;
        @(posedge clk);
        #1 pl_en = 0;
        mem_ref[i] = v;
    endtask

    task automatic drive_access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                                output int lat, output logic flt, output logic [31:0] rd,
                                output int nw, output logic dn2);
        int w0;
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        w0 = wr_cnt;
        req = 1; op = o; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!done) lat = 99;
        flt = fault;
        rd = rdata;
        @(posedge clk);
        #1 nw = wr_cnt - w0;
        dn2 = done;
    endtask

    task automatic test_reset();
        rst_b = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else pass++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else pass++;
        total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pass++;
        total++; if (mem_write_en !== 1'b0) $display("FAIL reset_wen got %b want 0", mem_write_en); else pass++;
        total++; if (mem_data_in !== 32'h0) $display("FAIL reset_wdata got %h want 0", mem_data_in); else pass++;
        @(negedge clk);
        rst_b = 0;
        for (int i = 0; i < 16; i++) preload(i, $urandom());
    endtask

    task automatic test_load_ext();
        int lat, nw;
        logic flt, dn2;
        logic [31:0] rd;
        preload(4, 32'h80010203);
        drive_access(LW, 32'h10, 0, lat, flt, rd, nw, dn2);
        total++; if (lat !== 2) $display("FAIL lw_latency got %0d want 2", lat); else pass++;
        total++; if (rd !== 32'h80010203) $display("FAIL lw_rdata got %h want 80010203", rd); else pass++;
        total++; if (flt !== 1'b0) $display("FAIL lw_fault got %b want 0", flt); else pass++;
        total++; if (nw !== 0) $display("FAIL lw_writes got %0d want 0", nw); else pass++;
        total++; if (dn2 !== 1'b0) $display("FAIL lw_done_width got %b want 0", dn2); else pass++;
        drive_access(LB, 32'h12, 0, lat, flt, rd, nw, dn2);
        total++; if (rd !== 32'h00000002) $display("FAIL lb_12 got %h want 00000002", rd); else pass++;
        drive_access(LB, 32'h10, 0, lat, flt, rd, nw, dn2);
        total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_10 got %h want ffffff80", rd); else pass++;
        drive_access(LBU, 32'h10, 0, lat, flt, rd, nw, dn2);
        total++; if (rd !== 32'h00000080) $display("FAIL lbu_10 got %h want 00000080", rd); else pass++;
        ref_rd = 32'h00000080;
    endtask

    task automatic test_sb_rmw();
        int lat, nw;
        logic flt, dn2;
        logic [31:0] rd;
        preload(4, 32'h11223344);
        drive_access(SB, 32'h11, 32'h000000AA, lat, flt, rd, nw, dn2);
        total++; if (lat !== 3) $display("FAIL sb_latency got %0d want 3", lat); else pass++;
        total++; if (nw !== 1) $display("FAIL sb_writes got %0d want 1", nw); else pass++;
        total++; if (last_wd !== 32'h11AA3344) $display("FAIL sb_wdata got %h want 11aa3344", last_wd); else pass++;
        total++; if (flt !== 1'b0) $display("FAIL sb_fault got %b want 0", flt); else pass++;
        mem_ref[4] = 32'h11AA3344;
    endtask

    task automatic test_fault();
        int lat, nw;
        logic flt, dn2;
        logic [31:0] rd;
        drive_access(SH, 32'h13, 32'h5555, lat, flt, rd, nw, dn2);
        total++; if (lat !== 1) $display("FAIL sh_mis_latency got %0d want 1", lat); else pass++;
        total++; if (flt !== 1'b1) $display("FAIL sh_mis_fault got %b want 1", flt); else pass++;
        total++; if (nw !== 0) $display("FAIL sh_mis_writes got %0d want 0", nw); else pass++;
        total++; if (mem[4] !== mem_ref[4]) $display("FAIL sh_mis_mem got %h want %h", mem[4], mem_ref[4]); else pass++;
        drive_access(LW, 32'h12, 0, lat, flt, rd, nw, dn2);
        total++; if (lat !== 1) $display("FAIL lw_mis_latency got %0d want 1", lat); else pass++;
        total++; if (flt !== 1'b1) $display("FAIL lw_mis_fault got %b want 1", flt); else pass++;
        total++; if (rd !== ref_rd) $display("FAIL lw_mis_rdata got %h want %h", rd, ref_rd); else pass++;
        total++; if (nw !== 0) $display("FAIL lw_mis_writes got %0d want 0", nw); else pass++;
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b000111};
        int lat, nw, idx;
        logic flt, dn2, f;
        logic [31:0] rd, a, d;
        logic [5:0] o;
        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 8)];
            a = $urandom();
            d = $urandom();
            idx = int'(a[5:2]);
            f = ref_fault(o, a);
            drive_access(o, a, d, lat, flt, rd, nw, dn2);
            if (!f && is_load(o)) ref_rd = ref_load(o, a, mem_ref[idx]);
            if (!f && is_store(o)) mem_ref[idx] = ref_store(o, a, mem_ref[idx], d);
            total++; if (lat !== ref_lat(o, a)) $display("FAIL rnd_latency op=%b a=%h got %0d want %0d", o, a, lat, ref_lat(o, a)); else pass++;
            total++; if (flt !== f) $display("FAIL rnd_fault op=%b a=%h got %b want %b", o, a, flt, f); else pass++;
            total++; if (rd !== ref_rd) $display("FAIL rnd_rdata op=%b a=%h got %h want %h", o, a, rd, ref_rd); else pass++;
            total++; if (nw !== ((!f && is_store(o)) ? 1 : 0)) $display("FAIL rnd_writes op=%b a=%h got %0d", o, a, nw); else pass++;
            total++; if (mem[idx] !== mem_ref[idx]) $display("FAIL rnd_mem op=%b a=%h got %h want %h", o, a, mem[idx], mem_ref[idx]); else pass++;
            total++; if (dn2 !== 1'b0) $display("FAIL rnd_done_width op=%b got %b want 0", o, dn2); else pass++;
        end
    endtask

    task automatic test_reset_mid();
        int w0, guard;
        @(negedge clk);
        w0 = wr_cnt;
        req = 1; op = SW; addr = 32'h20; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req = 0;
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_wr got %b want 1", busy); else pass++;
        rst_b = 1;
        #1;
        total++; if (mem_write_en !== 1'b0) $display("FAIL abort_wen got %b want 0", mem_write_en); else pass++;
        total++; if (mem_data_in !== 32'h0) $display("FAIL abort_wdata got %h want 0", mem_data_in); else pass++;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL abort_idle got %b want 0", busy); else pass++;
        total++; if (rdata !== 32'h0) $display("FAIL abort_rdata got %h want 0", rdata); else pass++;
        ref_rd = 0;
        rst_b = 0;
        req = 1; op = LW; addr = 32'h24;
        @(posedge clk);
        #1 req = 0;
        total++; if (busy !== 1'b1) $display("FAIL post_reset_accept got %b want 1", busy); else pass++;
        guard = 0;
        while (busy && guard < 40) begin
            @(posedge clk);
            #1 guard++;
        end
        ref_rd = mem_ref[9];
        total++; if (rdata !== ref_rd) $display("FAIL post_reset_rdata got %h want %h", rdata, ref_rd); else pass++;
        total++; if (wr_cnt !== w0) $display("FAIL abort_writes got %0d want %0d", wr_cnt, w0); else pass++;
        total++; if (mem[8] !== mem_ref[8]) $display("FAIL abort_mem got %h want %h", mem[8], mem_ref[8]); else pass++;
    endtask

    task automatic test_back_to_back();
        int per = L + 2;
        @(negedge clk);
        req = 1; op = LW; addr = 32'h30; wdata = 0;
        for (int i = 0; i < 3 * per; i++) begin
            @(posedge clk);
            #1;
            if (i == 3 * per - 1) req = 0;
            total++; if (busy !== (i % per != per - 1)) $display("FAIL b2b_busy cyc=%0d got %b want %b", i, busy, i % per != per - 1); else pass++;
            total++; if (done !== (i % per == per - 2)) $display("FAIL b2b_done cyc=%0d got %b want %b", i, done, i % per == per - 2); else pass++;
        end
        ref_rd = mem_ref[12];
        total++; if (rdata !== ref_rd) $display("FAIL b2b_rdata got %h want %h", rdata, ref_rd); else pass++;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL b2b_release got %b want 0", busy); else pass++;
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_sb_rmw();
        test_fault();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
